// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bundle: run-control and redirect inputs from the pipeline,
// PC / IF-ID control and performance counters back to it.
interface fetch_ctrl_if #(
  parameter int ROM_ADDR_BITS = 10,
  parameter int CNT_W         = 32
);
  logic                     go;
  logic                     halt_req;
  logic                     stall;
  logic                     br_taken;
  logic [31:0]              br_target;
  logic                     jr;
  logic [31:0]              jr_target;
  logic                     jmp;
  logic [31:0]              jmp_target;
  logic [31:0]              if_pc;
  logic [31:0]              if_pc4;
  logic [ROM_ADDR_BITS-1:0] rom_addr;
  logic                     ifid_enable;
  logic                     ifid_flush;
  logic                     halted;
  logic [CNT_W-1:0]         total_cycles;
  logic [CNT_W-1:0]         uncondi_branch_num;
  logic [CNT_W-1:0]         condi_branch_num;
  logic [CNT_W-1:0]         bubble_num;

  // master = pipeline / run-control side, slave = fetch controller
  modport master (
    output go, halt_req, stall, br_taken, br_target, jr, jr_target, jmp, jmp_target,
    input  if_pc, if_pc4, rom_addr, ifid_enable, ifid_flush, halted,
           total_cycles, uncondi_branch_num, condi_branch_num, bubble_num
  );
  modport slave (
    input  go, halt_req, stall, br_taken, br_target, jr, jr_target, jmp, jmp_target,
    output if_pc, if_pc4, rom_addr, ifid_enable, ifid_flush, halted,
           total_cycles, uncondi_branch_num, condi_branch_num, bubble_num
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC register, redirect selection, halt/go
// run-control FSM, IF/ID enable/flush and performance counters.
module fetch_ctrl #(
  parameter int          ROM_ADDR_BITS = 10,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          CNT_W         = 32,
  parameter int          GO_MODE       = 0,
  parameter int          SAT           = 0
) (
  input logic         clk,
  input logic         rst,
  fetch_ctrl_if.slave bus
);
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic             halted_reg;
  logic             go_prev_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      pc_plus4;
  logic [31:0]      pc_next;
  logic             active;
  logic             redirect;
  logic [3:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [4];

  assign pc_plus4 = pc_reg + 32'd4;
  // In level mode a halted core still fetches while go is held: single-step.
  assign active   = (state_reg == RUN && !bus.halt_req) ||
                    (state_reg == HALTED && GO_MODE == 0 && bus.go);
  assign redirect = active && (bus.br_taken || bus.jr || bus.jmp);

  always_comb begin
    pc_next = pc_reg;
    if (active) begin
      if (bus.br_taken)   pc_next = bus.br_target;
      else if (bus.jr)    pc_next = bus.jr_target;
      else if (bus.jmp)   pc_next = bus.jmp_target;
      else if (!bus.stall) pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RUN;
      halted_reg  <= 1'b0;
      go_prev_reg <= 1'b0;
      pc_reg      <= RESET_PC;
    end else begin
      go_prev_reg <= bus.go;
      pc_reg      <= pc_next;
      case (state_reg)
        RUN: begin
          if (bus.halt_req) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end
        end
        HALTED: begin
          if (GO_MODE == 1 && bus.go && !go_prev_reg) begin
            state_reg  <= RUN;
            halted_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  // Counter order: total cycles, unconditional, conditional, bubbles.
  assign cnt_inc[0] = (state_reg == RUN) || active;
  assign cnt_inc[1] = redirect && !bus.br_taken;
  assign cnt_inc[2] = redirect && bus.br_taken;
  assign cnt_inc[3] = (active && bus.stall && !redirect) || redirect;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && !(SAT != 0 && (&cnt_reg))) begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end
      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign bus.if_pc              = pc_reg;
  assign bus.if_pc4             = pc_plus4;
  assign bus.rom_addr           = pc_reg[ROM_ADDR_BITS+1:2];
  assign bus.ifid_enable        = (active && !bus.stall) || redirect;
  assign bus.ifid_flush         = redirect;
  assign bus.halted             = halted_reg;
  assign bus.total_cycles       = cnt_val[0];
  assign bus.uncondi_branch_num = cnt_val[1];
  assign bus.condi_branch_num   = cnt_val[2];
  assign bus.bubble_num         = cnt_val[3];
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written run-control and
// counter-overflow sequences, then random stimulus against a reference model.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, go = 1'b0, halt_req = 1'b0, stall = 1'b0;
  logic        br = 1'b0, jr = 1'b0, jmp = 1'b0;
  logic [31:0] bt = '0, jt = '0, mt = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // a: level go, wrap, 32-bit; b: edge go, saturate, 4-bit; c: level go, wrap, 4-bit
  fetch_ctrl_if #(.ROM_ADDR_BITS(10), .CNT_W(32)) a_if();
  fetch_ctrl_if #(.ROM_ADDR_BITS(10), .CNT_W(4))  b_if();
  fetch_ctrl_if #(.ROM_ADDR_BITS(10), .CNT_W(4))  c_if();

  assign a_if.go = go, a_if.halt_req = halt_req, a_if.stall = stall, a_if.br_taken = br,
         a_if.br_target = bt, a_if.jr = jr, a_if.jr_target = jt, a_if.jmp = jmp, a_if.jmp_target = mt;
  assign b_if.go = go, b_if.halt_req = halt_req, b_if.stall = stall, b_if.br_taken = br,
         b_if.br_target = bt, b_if.jr = jr, b_if.jr_target = jt, b_if.jmp = jmp, b_if.jmp_target = mt;
  assign c_if.go = go, c_if.halt_req = halt_req, c_if.stall = stall, c_if.br_taken = br,
         c_if.br_target = bt, c_if.jr = jr, c_if.jr_target = jt, c_if.jmp = jmp, c_if.jmp_target = mt;

  fetch_ctrl #(.ROM_ADDR_BITS(10), .RESET_PC(32'h0), .CNT_W(32), .GO_MODE(0), .SAT(0))
    dut_a (.clk(clk), .rst(rst), .bus(a_if));
  fetch_ctrl #(.ROM_ADDR_BITS(10), .RESET_PC(32'h0), .CNT_W(4), .GO_MODE(1), .SAT(1))
    dut_b (.clk(clk), .rst(rst), .bus(b_if));
  fetch_ctrl #(.ROM_ADDR_BITS(10), .RESET_PC(32'h0), .CNT_W(4), .GO_MODE(0), .SAT(0))
    dut_c (.clk(clk), .rst(rst), .bus(c_if));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table (instance a) ----------------
  // in = {rst, go, halt_req, stall, br_taken, jr, jmp}; efh = {enable, flush, halted}
  typedef struct {
    logic [6:0]  in;
    logic [31:0] bt, jt, mt;
    bit          chk;
    logic [31:0] pc;
    logic [2:0]  efh;
    logic [31:0] tc, ub, cb, bub;
  } vec_t;

  vec_t tv [33];

  task automatic fill_table();
    tv[0]  = '{7'b1000000, 0, 0, 0, 1'b0, 0,          3'b000, 0, 0, 0, 0};
    tv[1]  = '{7'b0000000, 0, 0, 0, 1'b1, 0,          3'b100, 0, 0, 0, 0};
    tv[2]  = '{7'b0000000, 0, 0, 0, 1'b1, 'h4,        3'b100, 1, 0, 0, 0};
    tv[3]  = '{7'b0000000, 0, 0, 0, 1'b1, 'h8,        3'b100, 2, 0, 0, 0};
    tv[4]  = '{7'b0000000, 0, 0, 0, 1'b1, 'hC,        3'b100, 3, 0, 0, 0};
    tv[5]  = '{7'b0000000, 0, 0, 0, 1'b1, 'h10,       3'b100, 4, 0, 0, 0};
    tv[6]  = '{7'b0000000, 0, 0, 0, 1'b1, 'h14,       3'b100, 5, 0, 0, 0};
    tv[7]  = '{7'b1000000, 0, 0, 0, 1'b0, 0,          3'b000, 0, 0, 0, 0};
    tv[8]  = '{7'b0000000, 0, 0, 0, 1'b1, 0,          3'b100, 0, 0, 0, 0};
    tv[9]  = '{7'b0000000, 0, 0, 0, 1'b1, 'h4,        3'b100, 1, 0, 0, 0};
    tv[10] = '{7'b0001000, 0, 0, 0, 1'b1, 'h8,        3'b000, 2, 0, 0, 0};
    tv[11] = '{7'b0001000, 0, 0, 0, 1'b1, 'h8,        3'b000, 3, 0, 0, 1};
    tv[12] = '{7'b0000000, 0, 0, 0, 1'b1, 'h8,        3'b100, 4, 0, 0, 2};
    tv[13] = '{7'b0000000, 0, 0, 0, 1'b1, 'hC,        3'b100, 5, 0, 0, 2};
    tv[14] = '{7'b0001110, 'h40, 'h80, 0, 1'b1, 'h10, 3'b110, 6, 0, 0, 2};
    tv[15] = '{7'b0000000, 0, 0, 0, 1'b1, 'h40,       3'b100, 7, 0, 1, 3};
    tv[16] = '{7'b0000001, 0, 0, 'h100, 1'b1, 'h44,   3'b110, 8, 0, 1, 3};
    tv[17] = '{7'b0000000, 0, 0, 0, 1'b1, 'h100,      3'b100, 9, 1, 1, 4};
    tv[18] = '{7'b0010010, 0, 'h200, 0, 1'b1, 'h104,  3'b000, 10, 1, 1, 4};
    tv[19] = '{7'b0000000, 0, 0, 0, 1'b1, 'h104,      3'b001, 11, 1, 1, 4};
    tv[20] = '{7'b0000000, 0, 0, 0, 1'b1, 'h104,      3'b001, 11, 1, 1, 4};
    tv[21] = '{7'b0100000, 0, 0, 0, 1'b1, 'h104,      3'b101, 11, 1, 1, 4};
    tv[22] = '{7'b0100000, 0, 0, 0, 1'b1, 'h108,      3'b101, 12, 1, 1, 4};
    tv[23] = '{7'b0100000, 0, 0, 0, 1'b1, 'h10C,      3'b101, 13, 1, 1, 4};
    tv[24] = '{7'b0000000, 0, 0, 0, 1'b1, 'h110,      3'b001, 14, 1, 1, 4};
    tv[25] = '{7'b0000000, 0, 0, 0, 1'b1, 'h110,      3'b001, 14, 1, 1, 4};
    tv[26] = '{7'b0100001, 0, 0, 0, 1'b1, 'h110,      3'b111, 14, 1, 1, 4};
    tv[27] = '{7'b0000000, 0, 0, 0, 1'b1, 0,          3'b001, 15, 2, 1, 5};
    tv[28] = '{7'b1000100, 'h40, 0, 0, 1'b0, 0,       3'b000, 0, 0, 0, 0};
    tv[29] = '{7'b0000000, 0, 0, 0, 1'b1, 0,          3'b100, 0, 0, 0, 0};
    tv[30] = '{7'b0000001, 0, 0, 'hFFFF_FFFC, 1'b1, 'h4, 3'b110, 1, 0, 0, 0};
    tv[31] = '{7'b0000000, 0, 0, 0, 1'b1, 'hFFFF_FFFC, 3'b100, 2, 1, 0, 1};
    tv[32] = '{7'b0000000, 0, 0, 0, 1'b1, 0,          3'b100, 3, 1, 0, 1};
  endtask

  task automatic set_inputs(input logic [6:0] in, input logic [31:0] b, input logic [31:0] j,
                            input logic [31:0] m);
    {rst, go, halt_req, stall, br, jr, jmp} = in;
    bt = b;
    jt = j;
    mt = m;
  endtask

  // One idle-target clock; outputs sampled 1 time unit after the edge.
  task automatic drive(input logic r, input logic g, input logic h);
    @(negedge clk);
    set_inputs({r, g, h, 4'b0000}, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int              go_mode [3] = '{0, 1, 0};
  int              sat     [3] = '{0, 1, 0};
  int              cw      [3] = '{32, 4, 4};
  logic [31:0]     m_pc    [3];
  bit              m_halt  [3];
  bit              m_gop   [3];
  longint unsigned m_cnt   [3][4];   // total, uncond, cond, bubble

  function automatic bit m_active(input int i);
    return (!m_halt[i] && !halt_req) || (m_halt[i] && go_mode[i] == 0 && go);
  endfunction

  function automatic bit m_redirect(input int i);
    return m_active(i) && (br || jr || jmp);
  endfunction

  function automatic longint unsigned bump(input longint unsigned v, input int i);
    longint unsigned mx = (64'd1 << cw[i]) - 64'd1;
    if (v == mx) return (sat[i] != 0) ? mx : 64'd0;
    return v + 64'd1;
  endfunction

  task automatic m_step(input int i);
    bit a, rd;
    if (rst) begin
      m_pc[i] = 32'h0;
      m_halt[i] = 1'b0;
      m_gop[i] = 1'b0;
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
      return;
    end
    a  = m_active(i);
    rd = m_redirect(i);
    if (!m_halt[i] || a)         m_cnt[i][0] = bump(m_cnt[i][0], i);
    if (rd && !br)               m_cnt[i][1] = bump(m_cnt[i][1], i);
    if (rd && br)                m_cnt[i][2] = bump(m_cnt[i][2], i);
    if ((a && stall) || rd)      m_cnt[i][3] = bump(m_cnt[i][3], i);
    if (a) m_pc[i] = br ? bt : jr ? jt : jmp ? mt : stall ? m_pc[i] : m_pc[i] + 32'd4;
    if (!m_halt[i] && halt_req)  m_halt[i] = 1'b1;
    else if (m_halt[i] && go_mode[i] == 1 && go && !m_gop[i]) m_halt[i] = 1'b0;
    m_gop[i] = go;
  endtask

  task automatic m_check(input int i, input logic [31:0] pc, input logic [31:0] pc4,
                         input logic [9:0] ra, input logic en, input logic fl, input logic hl,
                         input logic [31:0] tc, input logic [31:0] ub, input logic [31:0] cb,
                         input logic [31:0] bub);
    logic [31:0] epc;
    string tag;
    epc = m_pc[i];
    tag = $sformatf("rnd%0d", i);
    chk({tag, "_pc"},   pc,  epc);
    chk({tag, "_pc4"},  pc4, epc + 32'd4);
    chk({tag, "_rom"},  {22'h0, ra}, {22'h0, epc[11:2]});
    chk({tag, "_en"},   {31'h0, en}, {31'h0, (m_active(i) && !stall) || m_redirect(i)});
    chk({tag, "_fl"},   {31'h0, fl}, {31'h0, m_redirect(i)});
    chk({tag, "_halt"}, {31'h0, hl}, {31'h0, m_halt[i]});
    chk({tag, "_tc"},   tc,  32'(m_cnt[i][0]));
    chk({tag, "_ub"},   ub,  32'(m_cnt[i][1]));
    chk({tag, "_cb"},   cb,  32'(m_cnt[i][2]));
    chk({tag, "_bub"},  bub, 32'(m_cnt[i][3]));
  endtask

  initial begin
    fill_table();

    // directed table on instance a
    for (int v = 0; v < 33; v++) begin
      @(negedge clk);
      set_inputs(tv[v].in, tv[v].bt, tv[v].jt, tv[v].mt);
      #1;
      if (tv[v].chk) begin
        chk($sformatf("v%0d_pc", v),  a_if.if_pc,  tv[v].pc);
        chk($sformatf("v%0d_pc4", v), a_if.if_pc4, tv[v].pc + 32'd4);
        chk($sformatf("v%0d_rom", v), {22'h0, a_if.rom_addr}, {22'h0, tv[v].pc[11:2]});
        chk($sformatf("v%0d_en", v),  {31'h0, a_if.ifid_enable}, {31'h0, tv[v].efh[2]});
        chk($sformatf("v%0d_fl", v),  {31'h0, a_if.ifid_flush},  {31'h0, tv[v].efh[1]});
        chk($sformatf("v%0d_hl", v),  {31'h0, a_if.halted},      {31'h0, tv[v].efh[0]});
        chk($sformatf("v%0d_tc", v),  a_if.total_cycles,       tv[v].tc);
        chk($sformatf("v%0d_ub", v),  a_if.uncondi_branch_num, tv[v].ub);
        chk($sformatf("v%0d_cb", v),  a_if.condi_branch_num,   tv[v].cb);
        chk($sformatf("v%0d_bub", v), a_if.bubble_num,         tv[v].bub);
      end
      $display("[VEC] %0d in=%b pc=%h en=%b fl=%b halted=%b tc=%0d", v, tv[v].in,
               a_if.if_pc, a_if.ifid_enable, a_if.ifid_flush, a_if.halted, a_if.total_cycles);
      @(posedge clk);
    end

    // edge-mode halt / resume on instance b
    drive(1'b1, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b0, 1'b0);
    chk("b_run_pc", b_if.if_pc, 32'h20);
    drive(1'b0, 1'b0, 1'b1);
    chk("b_halted", {31'h0, b_if.halted}, 32'h1);
    chk("b_halt_pc", b_if.if_pc, 32'h20);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("b_frozen_pc", b_if.if_pc, 32'h20);
    chk("b_frozen_tc", 32'(b_if.total_cycles), 32'd9);
    drive(1'b0, 1'b1, 1'b0);
    chk("b_go_halted", {31'h0, b_if.halted}, 32'h0);
    chk("b_go_pc", b_if.if_pc, 32'h20);
    drive(1'b0, 1'b0, 1'b0);
    chk("b_resume_pc", b_if.if_pc, 32'h24);
    $display("[SEQ] go-edge resume pc=%h halted=%b", b_if.if_pc, b_if.halted);

    // 4-bit counter overflow: c wraps, b saturates
    drive(1'b1, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 1'b0, 1'b0);
    chk("c_wrap_tc", 32'(c_if.total_cycles), 32'd4);
    chk("b_sat_tc",  32'(b_if.total_cycles), 32'd15);
    $display("[SEQ] overflow c_tc=%0d b_tc=%0d", c_if.total_cycles, b_if.total_cycles);

    // random stimulus against the model, all three instances
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      rst      = (cyc == 0) || ($urandom_range(0, 39) == 0);
      go       = ($urandom_range(0, 2) == 0);
      halt_req = ($urandom_range(0, 24) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      br       = ($urandom_range(0, 5) == 0);
      jr       = ($urandom_range(0, 7) == 0);
      jmp      = ($urandom_range(0, 7) == 0);
      bt       = $urandom & 32'hFFFF_FFFC;
      jt       = $urandom & 32'hFFFF_FFFC;
      mt       = $urandom & 32'hFFFF_FFFC;
      #1;
      if (!rst) begin
        m_check(0, a_if.if_pc, a_if.if_pc4, a_if.rom_addr, a_if.ifid_enable, a_if.ifid_flush,
                a_if.halted, a_if.total_cycles, a_if.uncondi_branch_num,
                a_if.condi_branch_num, a_if.bubble_num);
        m_check(1, b_if.if_pc, b_if.if_pc4, b_if.rom_addr, b_if.ifid_enable, b_if.ifid_flush,
                b_if.halted, 32'(b_if.total_cycles), 32'(b_if.uncondi_branch_num),
                32'(b_if.condi_branch_num), 32'(b_if.bubble_num));
        m_check(2, c_if.if_pc, c_if.if_pc4, c_if.rom_addr, c_if.ifid_enable, c_if.ifid_flush,
                c_if.halted, 32'(c_if.total_cycles), 32'(c_if.uncondi_branch_num),
                32'(c_if.condi_branch_num), 32'(c_if.bubble_num));
      end
      $display("[RND] %0d rst=%b go=%b hr=%b st=%b br=%b jr=%b j=%b pc_a=%h pc_b=%h pc_c=%h",
               cyc, rst, go, halt_req, stall, br, jr, jmp, a_if.if_pc, b_if.if_pc, c_if.if_pc);
      @(posedge clk);
      for (int i = 0; i < 3; i++) m_step(i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Parametrised instruction-fetch controller for the 5-stage MIPS pipeline.
- Owns the PC register and redirect selection (branch / J / JR).
- Runs the halt/go run-control FSM and drives the IF/ID enable and flush.
- Maintains the performance counters: total cycles, unconditional and conditional branches, bubbles.

Parameters:
- ROM_ADDR_BITS, 10, word-address width of instruction ROM.
- RESET_PC, 32'h0000_0000, PC value after reset.
- CNT_W, 32, width of each performance counter.
- GO_MODE, 0, run-control mode: 0 = level (PC advances while go=1 when halted); 1 = edge (go rising edge resumes).
- SAT, 0, counter overflow policy: 0 = wrap; 1 = saturate at all-ones.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- go  in  1  run-control input (resume / step)
- halt_req  in  1  syscall-halt decoded in EX
- stall  in  1  load-use hazard from ID
- br_taken  in  1  conditional branch taken, resolved in EX
- br_target  in  32  branch target
- jr  in  1  JR resolved in EX
- jr_target  in  32  register target
- jmp  in  1  J/JAL resolved in EX
- jmp_target  in  32  jump target
- if_pc  out  32  current PC
- if_pc4  out  32  if_pc + 4
- rom_addr  out  ROM_ADDR_BITS  if_pc[ROM_ADDR_BITS+1:2]
- ifid_enable  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID synchronous clear
- halted  out  1  FSM in HALTED
- total_cycles  out  CNT_W  cycles spent not halted
- uncondi_branch_num  out  CNT_W  accepted jmp/jr count
- condi_branch_num  out  CNT_W  accepted br_taken count
- bubble_num  out  CNT_W  inserted bubbles

Behaviour:
- Clock/reset: one clock, clk; rst synchronous, active-high.
- Reset values: if_pc=RESET_PC; FSM=RUN; halted=0; all counters 0; go edge-detector history=0.
- FSM RUN -> HALTED: on halt_req=1, at the next edge. In that cycle the PC holds, and ifid_enable=0.
- FSM HALTED -> RUN (GO_MODE=0): while go=1, PC enables each cycle as if in RUN; the FSM stays HALTED until go is seen low, then remains HALTED. This is single-step by level.
- FSM HALTED -> RUN (GO_MODE=1): go rising edge (go=1, previous go=0) moves to RUN at the next edge. PC does not advance in the detecting cycle.
- active = (FSM==RUN & ~halt_req) | (FSM==HALTED & GO_MODE==0 & go).
- redirect = active & (br_taken | jr | jmp).
- Next PC priority, evaluated only when active:
  - br_taken -> br_target
  - else jr -> jr_target
  - else jmp -> jmp_target
  - else stall -> hold
  - else if_pc+4
- Redirect overrides stall: the stalled ID instruction is squashed.
- PC updates only when active; otherwise it holds.
- ifid_flush = redirect.
- ifid_enable = active & ~stall, or redirect. Flush has priority inside IF/ID.
- halt_req with a simultaneous redirect or stall: halt wins; the PC holds; no branch or bubble counter increments.
- Counters: at most one increment per counter per cycle; all update at the clock edge.
  - total_cycles +1 every cycle with FSM==RUN or active.
  - condi_branch_num +1 when redirect & br_taken.
  - uncondi_branch_num +1 when redirect & ~br_taken (jr or jmp).
  - bubble_num +1 per cycle with (active & stall & ~redirect) or redirect.
- Overflow: SAT=0 wraps all-ones -> 0. SAT=1 holds at all-ones.
- Width rules: if_pc4 is 32-bit modulo addition; 32'hFFFF_FFFC + 4 = 0.
- Mid-operation reset: rst dominates all inputs in the same cycle; outputs return to reset values at that edge.
- Outputs if_pc, halted and the counters are registered. ifid_enable and ifid_flush are combinational from inputs and state.

Test Plan:
- Reset, then 5 idle cycles, no events -> if_pc steps 0,4,8,C,10,14; total_cycles=5; other counters 0; ifid_enable=1.
- stall held 2 cycles at if_pc=8 -> if_pc stays 8 for 2 cycles, then C; bubble_num=2; ifid_enable=0 during the stall.
- br_taken=1 with br_target=0x40, jr=1 with jr_target=0x80, and stall=1, all in one cycle -> next if_pc=0x40; ifid_flush=1; condi_branch_num=1; uncondi_branch_num=0; bubble_num=1.
- halt_req at if_pc=0x20 with GO_MODE=1 -> halted=1, PC frozen, total_cycles frozen. go pulse 0->1 -> RUN after one cycle; PC resumes 0x24.
- GO_MODE=0, halted, go held 3 cycles -> PC advances 3 words; halted stays 1.
- CNT_W=4, 20 cycles with SAT=0 -> total_cycles=4. Same run with SAT=1 -> total_cycles=15.
- rst asserted mid-redirect -> if_pc=RESET_PC next edge; all counters 0; halted=0.
